vsru_config_ctrl: RTL



---
 rtl/vsru_pkg.sv | 22 ++
 rtl/vsru_config_ctrl_if.sv | 20 ++
 rtl/vsru_cfg_parser.sv | 88 ++++++++
 rtl/vsru_config_ctrl.sv | 84 ++++++++
 4 files changed

// File: rtl/vsru_pkg.sv
// Shared types and constants for the VSRU configuration sequencer.
package vsru_pkg;

  typedef enum logic [1:0] {
    S_HDR,
    S_VAL,
    S_WAIT
  } cfg_state_e;

  localparam int unsigned HDR_FLAG   = 7;
  localparam int unsigned HDR_CHAIN  = 0;
  localparam int unsigned NUM_CHAINS = 2;

  localparam logic [7:0] CONF_PASS = 8'd0;
  localparam logic [7:0] CONF_SUM  = 8'd1;

  // Header must carry the flag bit with all reserved bits clear.
  function automatic logic hdr_legal(input logic [7:0] b);
    return b[HDR_FLAG] && (b[6:1] == 6'd0);
  endfunction

endpackage

// File: rtl/vsru_config_ctrl_if.sv
// Byte-serial configuration command stream (valid/ready).
interface vsru_config_ctrl_if;

  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    output cfg_ready
  );

endinterface

// File: rtl/vsru_cfg_parser.sv
// Two-byte config command parser: header/value FSM, shadow value and sticky error.
module vsru_cfg_parser
  import vsru_pkg::*;
#(
  parameter int unsigned MAX_CONF = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  vsru_config_ctrl_if.slave       cfg,
  input  logic                    valid_i,
  input  logic                    eof_i,
  input  logic                    chain_i,
  output logic                    pending_o,
  output logic                    err_o,
  output logic                    commit_o,
  output logic                    commit_chain_o,
  output logic [7:0]              shadow_o
);

  localparam logic [7:0] MaxConfB = 8'(MAX_CONF);

  cfg_state_e state_q, state_d;
  logic       chain_q, chain_d;
  logic [7:0] shadow_q, shadow_d;
  logic       err_q, err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_HDR;
      chain_q  <= 1'b0;
      shadow_q <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      chain_q  <= chain_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    chain_d       = chain_q;
    shadow_d      = shadow_q;
    err_d         = err_q;
    cfg.cfg_ready = 1'b0;
    commit_o      = 1'b0;
    unique case (state_q)
      S_HDR: begin
        cfg.cfg_ready = 1'b1;
        if (cfg.cfg_valid) begin
          if (hdr_legal(cfg.cfg_data)) begin
            chain_d = cfg.cfg_data[HDR_CHAIN];
            state_d = S_VAL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_VAL: begin
        cfg.cfg_ready = 1'b1;
        if (cfg.cfg_valid) begin
          if (cfg.cfg_data <= MaxConfB) begin
            shadow_d = cfg.cfg_data;
            state_d  = S_WAIT;
          end else begin
            err_d   = 1'b1;
            state_d = S_HDR;
          end
        end
      end
      S_WAIT: begin
        // Only a real (valid) frame end on the targeted chain releases the shadow.
        if (valid_i && eof_i && (chain_i == chain_q)) begin
          commit_o = 1'b1;
          state_d  = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  assign pending_o      = (state_q == S_WAIT);
  assign err_o          = err_q;
  assign commit_chain_o = chain_q;
  assign shadow_o       = shadow_q;

endmodule

// File: rtl/vsru_config_ctrl.sv
// Per-chain active config plus one-stage vector pipeline feeding the reduce unit.
module vsru_config_ctrl
  import vsru_pkg::*;
#(
  parameter int unsigned N            = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MAX_CONF     = 1,
  parameter int unsigned DEFAULT_CONF = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  vsru_config_ctrl_if.slave                   cfg,
  input  logic                                valid_in,
  input  logic                                eof_in,
  input  logic                                chainId_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]        vector_in,
  output logic                                valid_out,
  output logic                                eof_out,
  output logic                                chainId_out,
  output logic [N-1:0][DATA_WIDTH-1:0]        vector_out,
  output logic [7:0]                          conf_byte_out,
  output logic                                cfg_pending_out,
  output logic                                err_out
);

  localparam logic [7:0] DefaultConfB = 8'(DEFAULT_CONF);

  logic                               commit;
  logic                               commit_chain;
  logic [7:0]                         shadow;
  logic [NUM_CHAINS-1:0][7:0]         active_q, active_d;
  logic                               valid_q, eof_q, chain_q;
  logic [N-1:0][DATA_WIDTH-1:0]       vector_q;
  logic [7:0]                         conf_q;

  vsru_cfg_parser #(
    .MAX_CONF (MAX_CONF)
  ) u_parser (
    .clk            (clk),
    .reset          (reset),
    .cfg            (cfg),
    .valid_i        (valid_in),
    .eof_i          (eof_in),
    .chain_i        (chainId_in),
    .pending_o      (cfg_pending_out),
    .err_o          (err_out),
    .commit_o       (commit),
    .commit_chain_o (commit_chain),
    .shadow_o       (shadow)
  );

  always_comb begin
    active_d = active_q;
    if (commit) begin
      active_d[commit_chain] = shadow;
    end
  end

  // conf_q samples active_q, not active_d, so an eof vector keeps its old config.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= {NUM_CHAINS{DefaultConfB}};
      valid_q  <= 1'b0;
      eof_q    <= 1'b0;
      chain_q  <= 1'b0;
      vector_q <= '0;
      conf_q   <= 8'd0;
    end else begin
      active_q <= active_d;
      valid_q  <= valid_in;
      eof_q    <= eof_in;
      chain_q  <= chainId_in;
      vector_q <= vector_in;
      conf_q   <= active_q[chainId_in];
    end
  end

  assign valid_out     = valid_q;
  assign eof_out       = eof_q;
  assign chainId_out   = chain_q;
  assign vector_out    = vector_q;
  assign conf_byte_out = conf_q;

endmodule
